// File: rtl/axi_rd_burst_master.sv
// AXI4 read burst engine: one AR transaction per request, returned beats streamed into
// the line FIFO, plus the frame address pointer and remaining-word count behind tail_status/tail_len.
module axi_rd_burst_master #(
    parameter int               ASIZE     = 32,
    parameter int               DSIZE     = 64,
    parameter int               LSIZE     = 9,
    parameter int               BURST_LEN = 100,
    parameter int               FRAME_LEN = 250,
    parameter logic [ASIZE-1:0] BASE_ADDR = '0,
    parameter int               CNT_W     = 24
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             fsync,
    input  logic             burst_req,
    input  logic             tail_req,
    input  logic [LSIZE-1:0] req_len,
    output logic             resp,
    output logic             done,
    output logic             tail_status,
    output logic [LSIZE-1:0] tail_len,
    output logic [ASIZE-1:0] araddr,
    output logic [7:0]       arlen,
    output logic [2:0]       arsize,
    output logic [1:0]       arburst,
    output logic             arvalid,
    input  logic             arready,
    input  logic [DSIZE-1:0] rdata,
    input  logic [1:0]       rresp,
    input  logic             rlast,
    input  logic             rvalid,
    output logic             rready,
    output logic             fifo_wr_en,
    output logic [DSIZE-1:0] fifo_wr_data,
    output logic             err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_AR     = 2'd1;
    localparam logic [1:0] ST_RDATA  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam int               BYTE_SHIFT = $clog2(DSIZE / 8);
    localparam logic [CNT_W-1:0] FRAME_INIT = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] BURST_LIM  = CNT_W'(BURST_LEN);

    logic [1:0]       r_state;
    logic [LSIZE-1:0] r_len;
    logic [LSIZE-1:0] r_beat_cnt;
    logic             r_flush;
    logic [ASIZE-1:0] r_addr;
    logic [CNT_W-1:0] r_remaining;
    logic             r_arvalid;
    logic [ASIZE-1:0] r_araddr;
    logic [7:0]       r_arlen;
    logic             r_rready;
    logic             r_resp;
    logic             r_done;
    logic             r_fifo_wr_en;
    logic [DSIZE-1:0] r_fifo_wr_data;
    logic             r_err;
    logic             r_tail_status;
    logic [LSIZE-1:0] r_tail_len;

    logic             w_flush_now;
    logic             w_beat_acc;
    logic             w_last_beat;
    logic             w_req;
    logic [CNT_W-1:0] w_len_ext;
    logic [ASIZE-1:0] w_len_bytes;
    logic [ASIZE-1:0] w_addr_nxt;
    logic [CNT_W-1:0] w_rem_nxt;

    // Per-cycle decode shared by the FSM and the pointer logic
    always_comb begin
        w_flush_now = r_flush | fsync;
        w_beat_acc  = r_rready & rvalid;
        w_last_beat = (r_beat_cnt == (r_len - LSIZE'(1)));
        w_req       = burst_req | tail_req;
        w_len_ext   = CNT_W'(r_len);
        w_len_bytes = ASIZE'(r_len) << BYTE_SHIFT;
    end

    // Next frame pointer / remaining count: reload on fsync, advance after each burst
    always_comb begin
        w_addr_nxt = r_addr;
        w_rem_nxt  = r_remaining;
        if (r_state == ST_IDLE) begin
            if (fsync) begin
                w_addr_nxt = BASE_ADDR;
                w_rem_nxt  = FRAME_INIT;
            end else begin
                w_addr_nxt = r_addr;
                w_rem_nxt  = r_remaining;
            end
        end else if (r_state == ST_FINISH) begin
            if (w_flush_now) begin
                w_addr_nxt = BASE_ADDR;
                w_rem_nxt  = FRAME_INIT;
            end else if (r_remaining >= w_len_ext) begin
                w_addr_nxt = r_addr + w_len_bytes;
                w_rem_nxt  = r_remaining - w_len_ext;
            end else begin
                w_addr_nxt = r_addr + w_len_bytes;
                w_rem_nxt  = '0;
            end
        end else begin
            w_addr_nxt = r_addr;
            w_rem_nxt  = r_remaining;
        end
    end

    // Pointer registers; tail outputs track the value remaining is about to take
    always_ff @(posedge clock) begin
        if (rst) begin
            r_addr        <= BASE_ADDR;
            r_remaining   <= FRAME_INIT;
            r_tail_status <= (FRAME_INIT <= BURST_LIM);
            r_tail_len    <= FRAME_INIT[LSIZE-1:0];
        end else begin
            r_addr        <= w_addr_nxt;
            r_remaining   <= w_rem_nxt;
            r_tail_status <= (w_rem_nxt <= BURST_LIM);
            r_tail_len    <= w_rem_nxt[LSIZE-1:0];
        end
    end

    // Burst FSM with AR/R channel handling and FIFO write pipeline
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_len          <= '0;
            r_beat_cnt     <= '0;
            r_flush        <= 1'b0;
            r_arvalid      <= 1'b0;
            r_araddr       <= BASE_ADDR;
            r_arlen        <= 8'd0;
            r_rready       <= 1'b0;
            r_resp         <= 1'b0;
            r_done         <= 1'b0;
            r_fifo_wr_en   <= 1'b0;
            r_fifo_wr_data <= '0;
            r_err          <= 1'b0;
        end else begin
            r_resp       <= 1'b0;
            r_done       <= 1'b0;
            r_fifo_wr_en <= 1'b0;
            if (w_beat_acc) begin
                r_fifo_wr_data <= rdata;
            end
            case (r_state)
                ST_IDLE: begin
                    r_flush <= 1'b0;
                    if (w_req) begin
                        r_len      <= req_len;
                        r_beat_cnt <= '0;
                        if (req_len == LSIZE'(0)) begin
                            r_state <= ST_FINISH;
                            r_resp  <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_AR;
                            r_arvalid <= 1'b1;
                            r_araddr  <= w_addr_nxt;
                            r_arlen   <= 8'(req_len - LSIZE'(1));
                        end
                    end
                end
                ST_AR: begin
                    r_flush <= w_flush_now;
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_resp    <= ~w_flush_now;
                        r_state   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    r_flush <= w_flush_now;
                    if (w_beat_acc) begin
                        // a flushed beat is still consumed from the bus but never stored
                        r_fifo_wr_en <= ~w_flush_now;
                        r_beat_cnt   <= r_beat_cnt + LSIZE'(1);
                        if ((rresp != 2'b00) || (rlast != w_last_beat)) begin
                            r_err <= 1'b1;
                        end
                        if (w_last_beat) begin
                            r_rready <= 1'b0;
                            r_done   <= ~w_flush_now;
                            r_state  <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    r_flush <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp         = r_resp;
    assign done         = r_done;
    assign tail_status  = r_tail_status;
    assign tail_len     = r_tail_len;
    assign araddr       = r_araddr;
    assign arlen        = r_arlen;
    assign arsize       = 3'(BYTE_SHIFT);
    assign arburst      = 2'b01;
    assign arvalid      = r_arvalid;
    assign rready       = r_rready;
    assign fifo_wr_en   = r_fifo_wr_en;
    assign fifo_wr_data = r_fifo_wr_data;
    assign err          = r_err;

endmodule

// File: doc/axi_rd_burst_master.md
# axi_rd_burst_master

Read-side AXI4 burst engine for the VDMA read path, directly downstream of the read FIFO status controller. It accepts burst/tail requests and a length, issues one AXI4 read-address transaction per request, and streams the returned beats into the read line FIFO. It answers the controller with `resp` (address accepted) and `done` (last beat stored). It also owns the frame address pointer and the remaining-word count, and from them drives the `tail_status`/`tail_len` that the controller consumes.

## Interface
Parameters:
- ASIZE, 32, AXI address width
- DSIZE, 64, AXI data width (bytes per beat = DSIZE/8, power of two)
- LSIZE, 9, request length width
- BURST_LEN, 100, normal burst length in beats (1..256)
- FRAME_LEN, 250, words (beats) per frame
- BASE_ADDR, 0, frame base byte address
- CNT_W, 24, remaining-word counter width

Ports:
- clock  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- fsync  in  1  frame start; restarts pointer and remaining count
- burst_req  in  1  normal-burst request, level, held until `resp`
- tail_req  in  1  tail-burst request, level, held until `resp`
- req_len  in  LSIZE  beats requested; sampled with the request
- resp  out  1  one-cycle pulse: AR handshake completed
- done  out  1  one-cycle pulse: final beat written to FIFO
- tail_status  out  1  remaining ≤ BURST_LEN
- tail_len  out  LSIZE  remaining[LSIZE-1:0]
- araddr  out  ASIZE / arlen  out  8 / arsize  out  3 / arburst  out  2 / arvalid  out  1 / arready  in  1  AXI4 AR channel
- rdata  in  DSIZE / rresp  in  2 / rlast  in  1 / rvalid  in  1 / rready  out  1  AXI4 R channel
- fifo_wr_en  out  1 / fifo_wr_data  out  DSIZE  line FIFO write port
- err  out  1  sticky: rresp≠OKAY or rlast mismatch; cleared only by rst

## Operation
- States: IDLE, AR_ISSUE, R_DATA, FINISH.
- IDLE: if `burst_req|tail_req` is high, latch `len = req_len`. If `len == 0`, go to FINISH without AXI traffic. Otherwise go to AR_ISSUE. `burst_req` and `tail_req` are treated identically, and the length always comes from `req_len`.
- AR_ISSUE: `arvalid=1`, `araddr=addr`, `arlen=len-1`, `arsize=log2(DSIZE/8)`, `arburst=INCR`. All are constant until `arvalid&&arready`. On the handshake, go to R_DATA.
- R_DATA: `rready=1`. Each `rvalid&&rready` writes `fifo_wr_en=1` and `fifo_wr_data=rdata` (registered, 1-cycle latency) and increments `beat_cnt`. When `beat_cnt == len-1` is accepted, go to FINISH.
- `rlast` must be high exactly on beat `len-1`. Any mismatch sets `err`. Any `rresp≠0` sets `err`. Data is still written in both cases.
- FINISH (1 cycle): `addr += len*(DSIZE/8)` (mod 2^ASIZE), `remaining -= len` (saturate at 0), then go to IDLE.
- Requests arriving outside IDLE are ignored. Requests are re-sampled only in IDLE, which is entered after `done`. The controller has dropped its request by then.
- fsync:
  - In IDLE: reload `addr=BASE_ADDR`, `remaining=FRAME_LEN` next cycle.
  - In any other state: set `flush`. The in-flight AR is held until accepted, as AXI requires. Remaining R beats are accepted but discarded (`fifo_wr_en=0`). `resp`/`done` are suppressed from then on.
  - Reload happens on return to IDLE, and `flush` clears.
- Reset values: state IDLE, `addr=BASE_ADDR`, `remaining=FRAME_LEN`, `arvalid=0`, `rready=0`, `resp=0`, `done=0`, `fifo_wr_en=0`, `err=0`, `flush=0`.

## Timing
- Request high in IDLE at cycle t gives `arvalid` high at t+1. This is also the earliest the handshake can complete.
- `resp` pulses the cycle after the AR handshake cycle.
- `rready` is high from the cycle after the AR handshake until the last beat is accepted. It is low in all other states.
- `fifo_wr_en` follows an accepted beat by 1 cycle.
- `done` pulses in the FINISH cycle, one cycle after the last beat is accepted. Pointer and count update in that same edge.
- `tail_status`/`tail_len` are registered from `remaining` and are valid from the cycle after FINISH or reload.
- `len==0` path: `resp` and `done` both pulse in the FINISH cycle, 1 cycle after the request.
- fsync and the last beat in the same cycle: the beat is discarded, no `done` is issued, and reload occurs.

## Test plan
- Full frame, FRAME_LEN=250, BURST_LEN=100, DSIZE=64, arready/rvalid always high: bursts at araddr 0x000 (arlen 99), 0x320 (arlen 99), then tail 50 at 0x640 (arlen 49). `tail_status` rises after the second `done`; `tail_len=50`. 250 FIFO writes in order.
- Backpressure: arready low for 5 cycles, rvalid toggling 1/0. arvalid and araddr stay stable until the handshake; exactly 100 FIFO writes; one `resp` and one `done` each.
- fsync asserted mid-R_DATA after 40 beats: remaining 60 beats accepted with `fifo_wr_en=0` and no `done`. Next request uses araddr 0x000, `remaining=250`.
- rlast early on beat 50 of a 100-beat burst, or rresp=SLVERR on any beat: `err` set and stays 1. Burst still completes after 100 beats with `done`.
- req_len=0 request: no arvalid; `resp` and `done` both pulse 1 cycle later; addr and remaining unchanged.
- rst asserted mid-burst: next cycle all outputs at reset values. State IDLE, araddr back to BASE_ADDR.
